// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with valid/ready request/response and programmable latency
// Supports B/H/W/D loads and stores (RISC-V funct3) and flags misaligned, out-of-range or illegal accesses.
module dmem_responder #(
    parameter int DEPTH_DW = 256,
    parameter int LATENCY  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IW = $clog2(DEPTH_DW);
    typedef enum logic [1:0] {OFF, IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic [63:0] mem [DEPTH_DW];
    logic [IW-1:0] idx;
    logic [2:0] off;
    logic [1:0] size;
    logic sx, err, accept;
    logic [7:0] be;
    logic [63:0] lane, ext, wbits;
    always_comb begin
        idx    = req_addr[3 +: IW];
        off    = req_addr[2:0];
        size   = req_funct3[1:0];
        sx     = ~req_funct3[2];
        accept = (state == IDLE) && req_valid;
        err    = (|req_addr[63:3+IW])
               || (size == 2'd1 && off[0])
               || (size == 2'd2 && |off[1:0])
               || (size == 2'd3 && |off)
               || (req_write && req_funct3[2])
               || (req_funct3 == 3'b111);
        lane   = mem[idx] >> {off, 3'b000};
        ext    = size == 2'd0 ? {{56{sx & lane[7]}}, lane[7:0]}
               : size == 2'd1 ? {{48{sx & lane[15]}}, lane[15:0]}
               : size == 2'd2 ? {{32{sx & lane[31]}}, lane[31:0]}
               : lane;
        be     = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF) << off;
        wbits  = req_wdata << {off, 3'b000};
        state_n = state == OFF  ? IDLE
                : state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
                : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
                : (rsp_ready ? IDLE : RESP);
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
    end
    // Array has no reset so stores committed before a reset survive it
    always_ff @(posedge clock) begin
        if (accept && req_write && !err)
            for (int i = 0; i < 8; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wbits[8*i +: 8];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= OFF;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt       <= 4'(LATENCY - 1);
                rsp_rdata <= (err || req_write) ? 64'd0 : ext;
                rsp_err   <= err;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test of dmem_responder at LATENCY=2 plus a LATENCY=1 instance
// Expected values are hand-computed; a shadow array tracks the LATENCY=2 instance's memory.
module tb_dmem_responder;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        v1 = 1'b0, ready1, rvalid1, err1;
    logic [63:0] rdata1;
    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [63:0] exp_mem [256];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_DW(256), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_DW(256), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(v1), .req_ready(ready1),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rvalid1), .rsp_ready(1'b1),
        .rsp_rdata(rdata1), .rsp_err(err1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full transaction on the LATENCY=2 instance; lat counts edges from accept to rsp_valid
    task automatic xact(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
        int k;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        k = 0;
        while (!req_ready && k < 20) begin tick(); k++; end
        tick();
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 20) begin tick(); k++; end
        lat = k; rd = rsp_rdata; er = rsp_err;
        tick();
    endtask

    task automatic op(input string tag, input logic w, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_er);
        logic [63:0] rd;
        logic er;
        int lat;
        xact(w, f3, a, d, rd, er, lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {63'd0, er}, {63'd0, exp_er});
        check({tag, ".lat"}, 64'(lat), 64'd2);
    endtask

    initial begin
        logic [63:0] rd;
        logic er;
        int lat, t0;
        logic [63:0] v_addr [5];
        logic [63:0] v_data [5];
        logic [63:0] v_exp [5];
        logic        v_w [5];
        logic [2:0]  v_f3 [5];
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        tick(); tick();
        check("rst.req_ready", {63'd0, req_ready}, 64'd0);
        check("rst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst.rsp_rdata", rsp_rdata, 64'd0);
        check("rst.rsp_err", {63'd0, rsp_err}, 64'd0);
        reset = 1'b0;
        tick();
        check("rst.ready_after", {63'd0, req_ready}, 64'd1);

        op("sd10", 1, 3'd3, 64'h10, 64'h1122334455667788, 64'd0, 0);
        exp_mem[2] = 64'h1122334455667788;
        op("ld10", 0, 3'd3, 64'h10, 0, 64'h1122334455667788, 0);

        op("lb17", 0, 3'd0, 64'h17, 0, 64'h11, 0);
        op("sb13", 1, 3'd0, 64'h13, 64'hABCDF0, 64'd0, 0);
        exp_mem[2] = 64'h11223344F0667788;
        op("lb13", 0, 3'd0, 64'h13, 0, 64'hFFFFFFFFFFFFFFF0, 0);
        op("lbu13", 0, 3'd4, 64'h13, 0, 64'hF0, 0);
        op("ld10b", 0, 3'd3, 64'h10, 0, 64'h11223344F0667788, 0);
        op("lh16", 0, 3'd1, 64'h16, 0, 64'h1122, 0);
        op("lh12", 0, 3'd1, 64'h12, 0, 64'hFFFFFFFFFFFFF066, 0);
        op("lw14", 0, 3'd2, 64'h14, 0, 64'h11223344, 0);
        op("lw10", 0, 3'd2, 64'h10, 0, 64'hFFFFFFFFF0667788, 0);
        op("lwu10", 0, 3'd6, 64'h10, 0, 64'hF0667788, 0);
        op("sh1a", 1, 3'd1, 64'h1A, 64'h1234BEEF, 64'd0, 0);
        exp_mem[3] = 64'h00000000BEEF0000;
        op("sd7f8", 1, 3'd3, 64'h7F8, 64'hCAFE, 64'd0, 0);
        exp_mem[255] = 64'hCAFE;

        op("lw12", 0, 3'd2, 64'h12, 0, 64'd0, 1);
        op("sd800", 1, 3'd3, 64'h800, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
        op("sh11", 1, 3'd1, 64'h11, 64'hFFFF, 64'd0, 1);
        op("swu", 1, 3'd6, 64'h20, 64'hFFFFFFFF, 64'd0, 1);
        op("f3_7", 0, 3'd7, 64'h10, 0, 64'd0, 1);
        for (int i = 0; i < 256; i++) begin
            xact(0, 3'd3, 64'(i) << 3, 0, rd, er, lat);
            check($sformatf("dw%0d", i), rd, exp_mem[i]);
        end

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd3; req_addr = 64'h10;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("hold.rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold.rdata", rsp_rdata, 64'h11223344F0667788);
            check("hold.req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("hs.req_ready", {63'd0, req_ready}, 64'd1);
        check("hs.rsp_valid", {63'd0, rsp_valid}, 64'd0);

        req_valid = 1'b1; req_funct3 = 3'd3; req_addr = 64'h10;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("midrst.req_ready", {63'd0, req_ready}, 64'd0);
        end
        reset = 1'b0;
        tick();
        check("postrst.req_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("postrst.no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        op("ld_after_rst", 0, 3'd3, 64'h18, 0, 64'h00000000BEEF0000, 0);

        v_w    = '{1, 1, 0, 0, 0};
        v_f3   = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
        v_addr = '{64'h0, 64'h8, 64'h0, 64'h8, 64'hC};
        v_data = '{64'h0123456789ABCDEF, 64'h8000000012345678, 0, 0, 0};
        v_exp  = '{64'd0, 64'd0, 64'h0123456789ABCDEF, 64'h8000000012345678, 64'hFFFFFFFF80000000};
        t0 = 0;
        for (int i = 0; i < 5; i++) begin
            int k;
            req_write = v_w[i]; req_funct3 = v_f3[i]; req_addr = v_addr[i]; req_wdata = v_data[i];
            v1 = 1'b1;
            k = 0;
            while (!ready1 && k < 20) begin tick(); k++; end
            tick();
            if (i > 0) check($sformatf("l1.spacing%0d", i), 64'(cyc - t0), 64'd2);
            t0 = cyc;
            check($sformatf("l1.valid%0d", i), {63'd0, rvalid1}, 64'd1);
            check($sformatf("l1.rdata%0d", i), rdata1, v_exp[i]);
            check($sformatf("l1.err%0d", i), {63'd0, err1}, 64'd0);
            tick();
        end
        v1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
